// File: rtl/bcd_gray_encoder_tx.sv
// -----------------------------------------------------------------------------
// bcd_gray_encoder_tx
//
// Purpose:
//   Takes binary/BCD words on a valid/ready interface and converts each one to
//   Gray code (g = b ^ (b >> 1)). Converted words go into a small FIFO. Each
//   word is then sent serially, MSB first, with an optional even-parity bit
//   and a frame-last marker. Back-to-back frames are sent with no idle gap.
//
// Ports:
//   clk       input   1      clock, rising edge
//   rst       input   1      asynchronous active-high reset
//   in_valid  input   1      in_data holds a word offered for transfer
//   in_data   input   WIDTH  binary/BCD word
//   in_ready  output  1      encoder can accept a word this cycle (registered)
//   tx_bit    output  1      serial data bit (registered)
//   tx_valid  output  1      tx_bit is a valid frame bit (registered)
//   tx_last   output  1      tx_bit is the final bit of the frame (registered)
//   err_cnt   output  8      saturating count of rejected non-BCD words
// -----------------------------------------------------------------------------
module bcd_gray_encoder_tx #(
  parameter int WIDTH      = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int PARITY_EN  = 1,
  parameter int CHECK_BCD  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             tx_bit,
  output logic             tx_valid,
  output logic             tx_last,
  output logic [7:0]       err_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned BCD_MAX = 9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Gray conversion
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] gray;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_gray
      if (gi == WIDTH - 1) begin : g_msb
        assign gray[gi] = in_data[gi];
      end else begin : g_low
        assign gray[gi] = in_data[gi] ^ in_data[gi+1];
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Input handshake
  // ---------------------------------------------------------------------------
  logic in_ready_q;
  logic bcd_bad;
  logic accept;
  logic push;
  logic pop;

  assign bcd_bad = (CHECK_BCD != 0) && (32'(in_data) > BCD_MAX);
  assign accept  = in_valid && in_ready_q;
  // A rejected word is consumed but never reaches the FIFO.
  assign push    = accept && !bcd_bad;

  // ---------------------------------------------------------------------------
  // FIFO: the extra MSB on each pointer tells full apart from empty
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             fifo_empty;
  logic             full_d;
  logic [WIDTH-1:0] rdata;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign rdata      = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    full_d = (wr_ptr_d[PTR_W] != rd_ptr_d[PTR_W]) &&
             (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= gray;
    end
  end

  // in_ready is registered from the next-cycle full flag, so it always equals
  // !full of the FIFO contents it is presented with.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      in_ready_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      in_ready_q <= !full_d;
    end
  end

  assign in_ready = in_ready_q;

  // ---------------------------------------------------------------------------
  // Error counter (saturating)
  // ---------------------------------------------------------------------------
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else if (accept && bcd_bad && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;

  // ---------------------------------------------------------------------------
  // Serializer FSM
  //
  // The registered outputs always show the bit of the current state. Loading a
  // word therefore drives its MSB onto tx_bit at the same edge. shreg_q keeps
  // the bits that have not been shown yet, and cnt_q counts them.
  // ---------------------------------------------------------------------------
  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             par_q;
  logic             tx_bit_q;
  logic             tx_valid_q;
  logic             tx_last_q;
  logic             frame_end;

  // frame_end is high on the cycle that shows the last bit of a frame.
  assign frame_end = (state_q == ST_PARITY) ||
                     ((state_q == ST_SHIFT) && (cnt_q == '0) && (PARITY_EN == 0));
  assign pop       = !fifo_empty && ((state_q == ST_IDLE) || frame_end);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      par_q      <= 1'b0;
      tx_bit_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
    end else if ((state_q == ST_IDLE) || frame_end) begin
      if (!fifo_empty) begin
        // Start the next frame right away. This is what keeps frames back to back.
        state_q    <= ST_SHIFT;
        shreg_q    <= rdata << 1;
        cnt_q      <= CNT_W'(WIDTH - 1);
        par_q      <= ^rdata;
        tx_bit_q   <= rdata[WIDTH-1];
        tx_valid_q <= 1'b1;
        tx_last_q  <= (WIDTH == 1) && (PARITY_EN == 0);
      end else begin
        state_q    <= ST_IDLE;
        tx_bit_q   <= 1'b0;
        tx_valid_q <= 1'b0;
        tx_last_q  <= 1'b0;
      end
    end else if (state_q == ST_SHIFT) begin
      if (cnt_q != '0) begin
        shreg_q    <= shreg_q << 1;
        cnt_q      <= cnt_q - 1'b1;
        tx_bit_q   <= shreg_q[WIDTH-1];
        tx_valid_q <= 1'b1;
        tx_last_q  <= (PARITY_EN == 0) && (cnt_q == CNT_W'(1));
      end else begin
        // Data bits are done. Reaching this branch means parity is enabled.
        state_q    <= ST_PARITY;
        tx_bit_q   <= par_q;
        tx_valid_q <= 1'b1;
        tx_last_q  <= 1'b1;
      end
    end else begin
      state_q    <= ST_IDLE;
      tx_bit_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
    end
  end

  assign tx_bit   = tx_bit_q;
  assign tx_valid = tx_valid_q;
  assign tx_last  = tx_last_q;

endmodule

// File: doc/bcd_gray_encoder_tx.md
Name: bcd_gray_encoder_tx

Overview:
- Encoder and transmitter for the 4-bit Gray-coded link that the team's Gray decoder consumes.
- Accepts binary/BCD words on a valid/ready interface and converts each one to Gray code (g = b XOR (b >> 1)).
- Buffers converted words in a small FIFO and shifts each one out serially, MSB first, with an optional even-parity bit and a frame-last marker.
- Sits between the digit source and the serial line feeding the decoder side.

Parameters:
- WIDTH, 4: data word width in bits.
- FIFO_DEPTH, 2: number of converted words buffered; power of two, at least 2.
- PARITY_EN, 1: when 1, append one even-parity bit per frame.
- CHECK_BCD, 1: when 1, reject input values above 9.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data holds a word offered for transfer.
- in_data  input  WIDTH  binary/BCD word.
- in_ready  output  1  encoder can accept a word this cycle.
- tx_bit  output  1  serial data bit.
- tx_valid  output  1  tx_bit is a valid frame bit this cycle.
- tx_last  output  1  tx_bit is the final bit of the current frame.
- err_cnt  output  8  count of rejected (non-BCD) words, saturating.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. rst asserted clears the following immediately, without waiting for a clock edge:
  - FIFO emptied; FSM to IDLE.
  - tx_bit=0, tx_valid=0, tx_last=0, err_cnt=0.
  - in_ready=0 while rst is high; in_ready=1 on the first cycle after release.
- Reset mid-frame aborts the frame; no partial bits resume after release.
- Acceptance:
  - A transfer occurs on a rising edge where in_valid && in_ready.
  - in_ready = !fifo_full.
  - A push is never allowed when the FIFO is full, even in a cycle that pops.
- Conversion at acceptance: the Gray word is written into the FIFO.
  - If CHECK_BCD=1 and in_data > 9, the word is consumed but not written, and err_cnt increments; it holds at 255.
- All outputs are registered.
- FSM states:
  - IDLE: tx_valid=0, tx_bit=0, tx_last=0. If the FIFO is non-empty, pop into the shift register, set bit counter cnt=WIDTH-1, and go to SHIFT.
  - SHIFT: tx_valid=1, tx_bit=shreg[MSB]; shift left each cycle and decrement cnt. When cnt==0:
    - If PARITY_EN=1, go to PARITY.
    - Otherwise this cycle has tx_last=1 and the end-of-frame rule applies.
  - PARITY: tx_valid=1, tx_bit = XOR of all Gray bits of the word, tx_last=1. The end-of-frame rule applies.
- End-of-frame rule, evaluated on the last-bit cycle:
  - FIFO non-empty: pop and go to SHIFT, so the next frame starts the following cycle with no gap.
  - FIFO empty: go to IDLE.
- Latency: a word accepted at edge N, with the FIFO empty and the FSM in IDLE, gives its first bit (MSB) valid after edge N+1.
- Frame length is WIDTH+PARITY_EN cycles. tx_valid stays high continuously across back-to-back frames.
- Simultaneous push and pop on a non-full FIFO are both performed; occupancy is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer bit.
- The serial side has no backpressure; once started, a frame always completes unless rst is asserted.

Test Plan:
- Single word: in_data=4'b0011 accepted at edge 0.
  - Required: from edge 1, tx_bit sequence 0,0,1,0, then parity 1 (Gray 0010).
  - tx_valid high for exactly 5 cycles; tx_last only on the 5th.
- Back-to-back: push 5 then 9 on consecutive cycles.
  - Required: Gray 0111 (parity 1) then 1101 (parity 1), i.e. bits 0,1,1,1,1,1,1,0,1,1.
  - tx_valid continuously high for 10 cycles; tx_last on cycles 5 and 10.
- Full FIFO: hold in_valid=1 with values 1,2,3,4.
  - Required: in_ready falls after the FIFO holds 2 words and a frame is in flight.
  - No word is lost; the serial output order is 1,2,3,4 (Gray 0001, 0011, 0010, 0110).
- Invalid BCD: push 12 (4'b1100), then 7.
  - Required: 12 consumed (in_ready stays high) with no frame emitted, and err_cnt=1.
  - 7 is then transmitted as 0,1,0,0, parity 1.
- Saturation: push 300 invalid words.
  - Required: err_cnt reaches 255 and holds.
- Reset mid-frame: assert rst during the 2nd bit of a frame for value 6.
  - Required: tx_valid, tx_bit and tx_last go to 0 with no clock edge; after release, no bits are output until a new word is pushed, and err_cnt=0.
